time_set_ctrl: RTL and testbench

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_pkg.sv | 58 +++++
 rtl/digit_field.sv | 51 +++++
 rtl/time_set_ctrl.sv | 168 ++++++++++++++++
 tb/tb_time_set_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/time_set_pkg.sv
// Shared types and limits for the keypad time-setting controller.
package time_set_pkg;

    localparam int unsigned HOUR_W     = 5;
    localparam int unsigned MINSEC_W   = 6;
    localparam int unsigned CNT_W      = 2;
    localparam int unsigned HOUR_MAX   = 23;
    localparam int unsigned MINSEC_MAX = 59;

    localparam logic [3:0] KEY_STAR = 4'hA;
    localparam logic [3:0] KEY_HASH = 4'hB;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOUR,
        S_MIN,
        S_SEC,
        S_COMMIT
    } state_e;

    typedef enum logic [1:0] {
        F_HOUR,
        F_MIN,
        F_SEC
    } field_e;

    typedef struct packed {
        logic [HOUR_W-1:0]   hour;
        logic [MINSEC_W-1:0] minute;
        logic [MINSEC_W-1:0] second;
    } hms_t;

    function automatic logic [MINSEC_W-1:0] field_max(input field_e f);
        return (f == F_HOUR) ? MINSEC_W'(HOUR_MAX) : MINSEC_W'(MINSEC_MAX);
    endfunction

    // Largest value the field register can hold; oversize entries clamp here and fail the range check.
    function automatic logic [MINSEC_W-1:0] field_sat(input field_e f);
        return (f == F_HOUR) ? MINSEC_W'((1 << HOUR_W) - 1) : MINSEC_W'((1 << MINSEC_W) - 1);
    endfunction

    function automatic state_e next_field(input state_e s);
        case (s)
            S_HOUR:  return S_MIN;
            S_MIN:   return S_SEC;
            default: return S_COMMIT;
        endcase
    endfunction

    function automatic state_e prev_field(input state_e s);
        case (s)
            S_SEC:   return S_MIN;
            S_MIN:   return S_HOUR;
            default: return S_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/digit_field.sv
// Two-digit decimal accumulator shared by the hour/minute/second fields:
// digit count register, next-value computation and range check.
module digit_field
    import time_set_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  field_e              sel_i,
    input  logic [MINSEC_W-1:0] val_i,
    input  logic                digit_i,
    input  logic [3:0]          digit_val_i,
    input  logic                clr_i,
    output logic [MINSEC_W-1:0] nxt_val_o,
    output logic [CNT_W-1:0]    cnt_o,
    output logic                in_range_o
);

    localparam int unsigned PROD_W = 10;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              take;
    logic [PROD_W-1:0] prod;

    always_comb begin
        take      = digit_i && (cnt_q < CNT_W'(2));
        prod      = PROD_W'(val_i) * PROD_W'(10) + PROD_W'(digit_val_i);
        nxt_val_o = val_i;
        if (take) begin
            nxt_val_o = (prod > PROD_W'(field_sat(sel_i))) ? field_sat(sel_i)
                                                            : prod[MINSEC_W-1:0];
        end
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (take) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        in_range_o = (val_i <= field_max(sel_i));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Keypad-driven hour/minute/second setting session with confirm, step-back,
// range check and inactivity timeout; emits a one-cycle load of the staged time.
module time_set_ctrl
    import time_set_pkg::*;
#(
    parameter int unsigned TIMEOUT_S = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                key_valid,
    input  logic [3:0]          key_code,
    input  logic                tick_1hz,
    output logic                hour_en,
    output logic                min_en,
    output logic                sec_en,
    output logic [HOUR_W-1:0]   set_hour,
    output logic [MINSEC_W-1:0] set_min,
    output logic [MINSEC_W-1:0] set_sec,
    output logic                load,
    output logic                busy,
    output logic                error
);

    localparam int unsigned INACT_W = 6;

    state_e              state_q, state_d;
    hms_t                set_q, set_d;
    logic [INACT_W-1:0]  inact_q, inact_d;
    logic                load_q, busy_q, error_q, err_d;
    logic [2:0]          en_q;

    field_e              sel;
    logic [MINSEC_W-1:0] cur_val, nxt_val, wr_val;
    logic [CNT_W-1:0]    cnt;
    logic                in_range, in_field, is_digit, is_star, is_hash;
    logic                clr_cnt, timeout, wr_en;

    // Route the active field through the shared accumulator.
    always_comb begin
        sel     = F_HOUR;
        cur_val = MINSEC_W'(set_q.hour);
        case (state_q)
            S_MIN: begin
                sel     = F_MIN;
                cur_val = set_q.minute;
            end
            S_SEC: begin
                sel     = F_SEC;
                cur_val = set_q.second;
            end
            default: ;
        endcase
    end

    assign in_field = (state_q == S_HOUR) || (state_q == S_MIN) || (state_q == S_SEC);
    assign is_digit = key_valid && (key_code <= 4'd9);
    assign is_star  = key_valid && (key_code == KEY_STAR);
    assign is_hash  = key_valid && (key_code == KEY_HASH);
    // Any key, even an ignored code, beats a coincident timeout.
    assign timeout  = in_field && tick_1hz && !key_valid
                   && (inact_q == INACT_W'(TIMEOUT_S - 1));

    digit_field u_digit_field (
        .clock       (clock),
        .reset       (reset),
        .sel_i       (sel),
        .val_i       (cur_val),
        .digit_i     (in_field && is_digit),
        .digit_val_i (key_code),
        .clr_i       (clr_cnt),
        .nxt_val_o   (nxt_val),
        .cnt_o       (cnt),
        .in_range_o  (in_range)
    );

    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        inact_d = inact_q;
        err_d   = 1'b0;
        clr_cnt = 1'b0;
        wr_en   = 1'b0;
        wr_val  = '0;

        if (key_valid) begin
            inact_d = '0;
        end else if (tick_1hz && (state_q != S_IDLE)) begin
            inact_d = inact_q + INACT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HOUR;
                    set_d   = '0;
                    clr_cnt = 1'b1;
                    inact_d = '0;
                end
            end
            S_HOUR, S_MIN, S_SEC: begin
                if (is_digit) begin
                    wr_en  = 1'b1;
                    wr_val = nxt_val;
                end else if (is_hash) begin
                    clr_cnt = 1'b1;
                    if (in_range) begin
                        state_d = next_field(state_q);
                    end else begin
                        err_d = 1'b1;
                        wr_en = 1'b1;
                    end
                end else if (is_star) begin
                    clr_cnt = 1'b1;
                    if (cnt != '0) begin
                        wr_en = 1'b1;
                    end else begin
                        state_d = prev_field(state_q);
                    end
                end else if (timeout) begin
                    state_d = S_IDLE;
                    clr_cnt = 1'b1;
                    inact_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_en) begin
            case (sel)
                F_HOUR:  set_d.hour   = HOUR_W'(wr_val);
                F_MIN:   set_d.minute = wr_val;
                default: set_d.second = wr_val;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            set_q   <= '0;
            inact_q <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            inact_q <= inact_d;
            load_q  <= (state_d == S_COMMIT);
            busy_q  <= (state_d != S_IDLE);
            error_q <= err_d;
            en_q    <= {state_d == S_HOUR, state_d == S_MIN, state_d == S_SEC};
        end
    end

    assign hour_en  = en_q[2];
    assign min_en   = en_q[1];
    assign sec_en   = en_q[0];
    assign set_hour = set_q.hour;
    assign set_min  = set_q.minute;
    assign set_sec  = set_q.second;
    assign load     = load_q;
    assign busy     = busy_q;
    assign error    = error_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: load/error pulses go through a scoreboard queue,
// field and state outputs are checked inline after each step.
module tb_time_set_ctrl;

    localparam logic [3:0] K_STAR = 4'hA;
    localparam logic [3:0] K_HASH = 4'hB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       tick = 1'b0;
    logic       hour_en, min_en, sec_en, load, busy, error;
    logic [4:0] set_hour;
    logic [5:0] set_min, set_sec;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       is_load;
        logic [4:0] h;
        logic [5:0] m;
        logic [5:0] s;
    } exp_t;

    exp_t exp_q[$];
    exp_t got;

    time_set_ctrl #(.TIMEOUT_S(10)) dut (
        .clock     (clk),
        .reset     (rst_n),
        .start     (start),
        .key_valid (key_valid),
        .key_code  (key_code),
        .tick_1hz  (tick),
        .hour_en   (hour_en),
        .min_en    (min_en),
        .sec_en    (sec_en),
        .set_hour  (set_hour),
        .set_min   (set_min),
        .set_sec   (set_sec),
        .load      (load),
        .busy      (busy),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic tick_once();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic press_tick(input logic [3:0] c);
        tick = 1'b1;
        press(c);
        tick = 1'b0;
    endtask

    task automatic exp_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        exp_q.push_back('{is_load: 1'b1, h: h, m: m, s: s});
    endtask

    task automatic exp_err();
        exp_q.push_back('{is_load: 1'b0, h: 5'd0, m: 6'd0, s: 6'd0});
    endtask

    function automatic logic [31:0] en3();
        return 32'({hour_en, min_en, sec_en});
    endfunction

    // Every load or error pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (load === 1'b1 || error === 1'b1) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL sb_unexpected observed load=%0b error=%0b expected=no pulse", load, error);
            end
            if (exp_q.size() != 0) begin
                got = exp_q.pop_front();
                check("sb_kind_load", 32'(load), 32'(got.is_load));
                if (got.is_load) begin
                    check("sb_hour", 32'(set_hour), 32'(got.h));
                    check("sb_min", 32'(set_min), 32'(got.m));
                    check("sb_sec", 32'(set_sec), 32'(got.s));
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_en", en3(), 0);
        check("rst_load_err", 32'({load, error}), 0);
        check("rst_fields", 32'({set_hour, set_min, set_sec}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full session 12:34:56
        pulse_start();
        check("s1_busy", 32'(busy), 1);
        check("s1_hour_en", en3(), 4);
        press(4'd1); press(4'd2);
        check("s1_hour12", 32'(set_hour), 12);
        press(K_HASH);
        check("s1_min_en", en3(), 2);
        press(4'd3); press(4'd4); press(K_HASH);
        check("s1_sec_en", en3(), 1);
        check("s1_min34", 32'(set_min), 34);
        press(4'd5); press(4'd6);
        exp_load(5'd12, 6'd34, 6'd56);
        press(K_HASH);
        check("s1_load_lat1", 32'(load), 1);
        check("s1_commit_busy", 32'(busy), 1);
        check("s1_commit_en", en3(), 0);
        @(negedge clk);
        check("s1_load_end", 32'(load), 0);
        check("s1_idle_busy", 32'(busy), 0);
        check("s1_hold", 32'({set_hour, set_min, set_sec}), 32'({5'd12, 6'd34, 6'd56}));

        // Out-of-range hour, then out-of-range minute
        pulse_start();
        check("s2_cleared", 32'({set_hour, set_min, set_sec}), 0);
        press(4'd2); press(4'd5);
        check("s2_hour25", 32'(set_hour), 25);
        exp_err();
        press(K_HASH);
        check("s2_err", 32'(error), 1);
        check("s2_stay_hour", en3(), 4);
        check("s2_hour0", 32'(set_hour), 0);
        @(negedge clk);
        check("s2_err_end", 32'(error), 0);
        press(4'd0); press(4'd9); press(K_HASH);
        check("s2_min_en", en3(), 2);
        check("s2_hour9", 32'(set_hour), 9);
        press(4'd9); press(4'd9);
        exp_err();
        press(K_HASH);
        check("s2_min99_err", 32'(error), 1);
        check("s2_stay_min", en3(), 2);
        check("s2_min0", 32'(set_min), 0);
        press(K_STAR);
        check("s2_back_hour", en3(), 4);
        press(K_STAR);
        check("s2_idle", 32'(busy), 0);

        // Clear field, step back, abort
        pulse_start();
        press(4'd1); press(K_HASH);
        check("s3_min_en", en3(), 2);
        press(4'd7);
        check("s3_min7", 32'(set_min), 7);
        press(K_STAR);
        check("s3_clear_stay", en3(), 2);
        check("s3_min0", 32'(set_min), 0);
        press(K_STAR);
        check("s3_back_hour", en3(), 4);
        check("s3_hour1", 32'(set_hour), 1);
        press(K_STAR);
        check("s3_abort_busy", 32'(busy), 0);
        check("s3_abort_en", en3(), 0);

        // Inactivity timeout; key on the tenth tick keeps the session
        pulse_start();
        repeat (9) tick_once();
        check("s4_nine_busy", 32'(busy), 1);
        tick_once();
        check("s4_timeout", 32'(busy), 0);
        check("s4_no_load", 32'(load), 0);
        pulse_start();
        repeat (9) tick_once();
        press_tick(4'hC);
        check("s4_key_wins", 32'(busy), 1);
        check("s4_still_hour", en3(), 4);
        check("s4_code_c_noop", 32'(set_hour), 0);
        repeat (9) tick_once();
        check("s4_restart_busy", 32'(busy), 1);
        tick_once();
        check("s4_timeout2", 32'(busy), 0);

        // Limits 23:59, third digit ignored, start ignored, '#' with no digits
        pulse_start();
        press(4'd2);
        pulse_start();
        check("s6_start_ign", 32'(set_hour), 2);
        check("s6_busy", 32'(busy), 1);
        press(4'd3); press(K_HASH);
        check("s6_hour23_ok", en3(), 2);
        press(4'd5); press(4'd9); press(4'd9);
        check("s6_third_ign", 32'(set_min), 59);
        press(K_HASH);
        check("s6_min59_ok", en3(), 1);
        exp_load(5'd23, 6'd59, 6'd0);
        press(K_HASH);
        check("s6_load", 32'(load), 1);
        @(negedge clk);

        // Reset in the middle of a session
        pulse_start();
        press(4'd1); press(4'd2); press(4'd3);
        check("s5_hour12", 32'(set_hour), 12);
        press(K_HASH); press(4'd4);
        check("s5_min4", 32'(set_min), 4);
        check("s5_min_en", en3(), 2);
        #2 rst_n = 1'b0;
        #1;
        check("s5_rst_busy", 32'(busy), 0);
        check("s5_rst_en", en3(), 0);
        check("s5_rst_fields", 32'({set_hour, set_min, set_sec}), 0);
        check("s5_rst_load", 32'({load, error}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("s5_after_busy", 32'(busy), 0);
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
